mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Arbitrates the CPU's unified single-port synchronous memory between the fetch stage (I-port) and the memory stage load/store unit (D-port). Grants are combinational in the request cycle. Read data returns one cycle later, tagged to the granted requester. Data accesses win contested cycles to keep the older instruction moving, and a streak counter guarantees fetch forward progress.

## Interface
Parameters:
- ADDR_W, 14, word-address width (64 KiB memory)
- MAX_STREAK, 4, consecutive contested D-grants allowed before the I-port is forced; range 1..15

Ports:
- CLK  in  1  system clock, rising edge
- RST_N  in  1  asynchronous, active-low reset
- if_req  in  1  fetch read request
- if_addr  in  ADDR_W  fetch word address
- if_gnt  out  1  fetch request accepted this cycle
- if_rvalid  out  1  fetch read data valid
- if_rdata  out  32  fetch read data
- d_req  in  1  data request
- d_we  in  1  1 = store, 0 = load
- d_be  in  4  store byte enables
- d_addr  in  ADDR_W  data word address
- d_wdata  in  32  store data, already lane-aligned
- d_gnt  out  1  data request accepted this cycle
- d_rvalid  out  1  load data valid
- d_rdata  out  32  load data, full word; the load unit extracts and extends it
- mem_en  out  1  memory access enable
- mem_we  out  4  memory byte write enables
- mem_addr  out  ADDR_W  memory word address
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory read data, valid one cycle after an enabled read
- stall_if  out  1  if_req & ~if_gnt
- stall_d  out  1  d_req & ~d_gnt

## Operation
- State:
  - streak counter, 4 bits
  - read-tag register: NONE, I or D
- Grant decision each cycle:
  - Only one requester active: that requester is granted.
  - Both active and streak < MAX_STREAK: D is granted and streak increments.
  - Both active and streak == MAX_STREAK: I is granted and streak clears.
  - Streak also clears in any cycle with if_req low, or whenever I is granted.
- Memory drive:
  - mem_en = if_gnt | d_gnt. mem_addr, mem_we and mem_wdata come from the winner.
  - An I grant forces mem_we = 0. A D load drives mem_we = 0; a D store drives mem_we = d_be.
  - With no grant, mem_en = 0, mem_we = 0, and address and data are 0.
- Read tag: next tag is I on an I grant, D on a D load, and NONE on a store or idle cycle.
- Return path:
  - if_rvalid = (tag == I); d_rvalid = (tag == D).
  - The rdata of the tagged port is mem_rdata. The other port's rdata is 0.
- Stores produce no rvalid.
- A store with d_be = 0 is still granted, issues mem_en with mem_we = 0, and clears the tag.
- Requesters may change address or drop req freely while not granted. No request is queued internally.

## Timing
- Reset (asynchronous, immediate on RST_N low):
  - streak = 0, tag = NONE
  - all outputs 0 apart from the combinational grant and memory-drive logic, which continues to follow the inputs
- Grant latency: 0 cycles, combinational from req.
- Read latency: 1 cycle from grant to rvalid.
- Back-to-back grants are allowed every cycle; the memory is fully pipelined at one access per cycle.
- Simultaneous rvalid and a new grant in the same cycle is legal.
- Reset asserted while a read is outstanding cancels its rvalid; the returned data is discarded.
- The counter saturates at MAX_STREAK and never wraps.

## Structure
- Shared package (cpu_pkg) holds:
  - tag encoding: TAG_NONE = 2'b00, TAG_I = 2'b01, TAG_D = 2'b10
  - MAX_STREAK default
  - the ADDR_W constant shared with the memory and fetch units
- One natural sub-module, streak_guard: holds the counter and outputs force_i.
- The grant mux, tag register and return routing stay in the top arbiter.

## Test plan
- Lone fetch: if_req = 1, if_addr = 0x010, mem holds 0x00500093 -> if_gnt = 1 the same cycle; next cycle if_rvalid = 1, if_rdata = 0x00500093, d_rvalid = 0.
- Lone store: d_req = 1, d_we = 1, d_be = 4'b0011, d_addr = 0x3E57, d_wdata = 0x0000BEEF -> mem_we = 0011, mem_addr = 0x3E57; no rvalid follows; a later load of 0x3E57 returns BEEF in the low half with the upper bytes unchanged.
- Contention, MAX_STREAK = 4: both requests held for 10 cycles -> grant order D,D,D,D,I,D,D,D,D,I; stall_if is high on exactly the 8 D cycles.
- Streak reset: 3 contested D grants, one cycle with if_req = 0, then contention resumes -> 4 more D grants before I is forced.
- Load/fetch interleave: D load to 0x100 in cycle n, I fetch in cycle n+1 -> d_rvalid in n+1 with mem[0x100], if_rvalid in n+2; the rdata of the non-tagged port is 0 in each cycle.
- Reset mid-read: RST_N low in the cycle after a granted load -> d_rvalid = 0 immediately and streak = 0; after release, the first contested cycle grants D.

Source files
------------

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared CPU constants and types used by the memory-port
//               arbiter, the fetch unit and the unified memory.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

  // Word-address width of the unified 64 KiB memory
  localparam int MEM_ADDR_W = 14;

  // Default number of back-to-back contested data grants before fetch wins
  localparam int DEF_MAX_STREAK = 4;

  // Width of the fetch-starvation streak counter (MAX_STREAK range 1..15)
  localparam int STREAK_W = 4;

  // Owner of the read data arriving from memory in the following cycle
  typedef enum logic [1:0] {
    TAG_NONE = 2'b00,
    TAG_I    = 2'b01,
    TAG_D    = 2'b10
  } tag_e;

  // Byte write enables presented to memory for a data-port access
  function automatic logic [3:0] store_we(input logic we, input logic [3:0] be);
    return we ? be : 4'b0000;
  endfunction

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/streak_guard.sv
`default_nettype none
// ============================================================================
// Module      : streak_guard
// Description : Counts consecutive contested cycles won by the data port and
//               forces a fetch grant once the limit is reached, so that fetch
//               always makes forward progress.
// Revision    : 1.0 - initial release
// ============================================================================
module streak_guard
  import cpu_pkg::*;
#(
  parameter int MAX_STREAK = DEF_MAX_STREAK
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic if_req_i,
  input  logic d_req_i,
  output logic force_i_o   // fetch must win this cycle if contested
);

  localparam logic [STREAK_W-1:0] C_MAX = STREAK_W'(MAX_STREAK);

  logic [STREAK_W-1:0] streak_q;
  logic [STREAK_W-1:0] streak_d;

  // Limit reached: the next contested cycle belongs to fetch
  assign force_i_o = (streak_q == C_MAX);

  // Count only contested cycles that data wins; everything else restarts the
  // streak. Incrementing only below the limit makes the counter saturate.
  always_comb begin
    streak_d = '0;
    if (if_req_i && d_req_i && !force_i_o) begin
      streak_d = streak_q + 1'b1;
    end
  end

  // Streak register, cleared asynchronously
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      streak_q <= '0;
    end else begin
      streak_q <= streak_d;
    end
  end

endmodule : streak_guard
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one single-port synchronous memory between the fetch
//               stage (I-port) and the load/store unit (D-port). Grants are
//               combinational; read data returns one cycle later and is
//               routed to the port that issued the read.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
  import cpu_pkg::*;
#(
  parameter int ADDR_W     = MEM_ADDR_W,
  parameter int MAX_STREAK = DEF_MAX_STREAK
) (
  input  logic              CLK,
  input  logic              RST_N,
  // Fetch port
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [31:0]       if_rdata,
  // Load/store port
  input  logic              d_req,
  input  logic              d_we,
  input  logic [3:0]        d_be,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  // Memory side
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  // Stall indications back to the pipeline
  output logic              stall_if,
  output logic              stall_d
);

  logic force_i;
  tag_e tag_q;
  tag_e tag_d;

  streak_guard #(
    .MAX_STREAK (MAX_STREAK)
  ) u_streak_guard (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .if_req_i  (if_req),
    .d_req_i   (d_req),
    .force_i_o (force_i)
  );

  // Data wins contested cycles unless the streak guard hands the slot to fetch
  assign if_gnt   = if_req & (~d_req | force_i);
  assign d_gnt    = d_req & ~if_gnt;
  assign stall_if = if_req & ~if_gnt;
  assign stall_d  = d_req & ~d_gnt;

  // Memory drive from the winner, plus the owner of next cycle's read data
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 4'b0000;
    mem_addr  = '0;
    mem_wdata = '0;
    tag_d     = TAG_NONE;
    if (if_gnt) begin
      mem_en   = 1'b1;
      mem_addr = if_addr;
      tag_d    = TAG_I;
    end else if (d_gnt) begin
      mem_en    = 1'b1;
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
      // A store with no byte enables still occupies the slot but writes nothing
      mem_we    = store_we(d_we, d_be);
      tag_d     = d_we ? TAG_NONE : TAG_D;
    end
  end

  // Read-tag register; reset drops any read still in flight
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      tag_q <= TAG_NONE;
    end else begin
      tag_q <= tag_d;
    end
  end

  // Return routing: only the tagged port sees memory data, the other reads 0
  assign if_rvalid = (tag_q == TAG_I);
  assign d_rvalid  = (tag_q == TAG_D);
  assign if_rdata  = if_rvalid ? mem_rdata : 32'h0;
  assign d_rdata   = d_rvalid  ? mem_rdata : 32'h0;

endmodule : mem_port_arbiter
`default_nettype wire
